// File: rtl/vend_sequencer.sv
// Newspaper vending slot controller: collects coins, runs the dispense handshake,
// then pays change one unit per hopper handshake. Stock tracking, cancel/timeout refund.
module vend_sequencer #(
  parameter int PRICE      = 3,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  input  logic                restock,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic                busy
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  STOCK_C   = STOCK_W'(STOCK_INIT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_RETURN} state_t;

  state_t              state, state_nx;
  logic [STOCK_W-1:0]  stock, stock_nx;
  logic [CREDIT_W-1:0] credit_nx, credit_sum;
  logic [IDLE_W-1:0]   idle_cnt, idle_nx;
  logic                coin, reject_nx;

  always_comb begin
    coin       = coin_valid && (coin_val != 2'd0);
    credit_sum = credit + (coin ? CREDIT_W'(coin_val) : '0);
    state_nx   = state;
    stock_nx   = stock;
    credit_nx  = credit;
    idle_nx    = idle_cnt;
    reject_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin) begin
          if (stock != '0) begin
            credit_nx = CREDIT_W'(coin_val);
            idle_nx   = '0;
            state_nx  = S_COLLECT;
          end else begin
            reject_nx = 1'b1;
          end
        end
        if (restock) stock_nx = STOCK_C;
      end
      S_COLLECT: begin
        // Cancel wins over a sale completing on the same edge.
        if (cancel) begin
          credit_nx = credit_sum;
          state_nx  = S_RETURN;
        end else if (credit_sum >= PRICE_C) begin
          credit_nx = credit_sum;
          state_nx  = S_DISPENSE;
        end else if (coin) begin
          credit_nx = credit_sum;
          idle_nx   = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nx = S_RETURN;
        end else begin
          idle_nx = idle_cnt + IDLE_W'(1);
        end
      end
      S_DISPENSE: begin
        reject_nx = coin;
        if (disp_ack) begin
          stock_nx  = stock - STOCK_W'(1);
          credit_nx = credit - PRICE_C;
          state_nx  = (credit > PRICE_C) ? S_RETURN : S_IDLE;
        end
      end
      S_RETURN: begin
        reject_nx = coin;
        if (chg_ack) begin
          credit_nx = (credit != '0) ? credit - CREDIT_W'(1) : '0;
          if (credit <= CREDIT_W'(1)) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stock       <= STOCK_C;
      credit      <= '0;
      idle_cnt    <= '0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      sold_out    <= (STOCK_INIT == 0);
    end else begin
      state       <= state_nx;
      stock       <= stock_nx;
      credit      <= credit_nx;
      idle_cnt    <= idle_nx;
      disp_req    <= (state_nx == S_DISPENSE);
      chg_req     <= (state_nx == S_RETURN);
      coin_reject <= reject_nx;
      busy        <= (state_nx == S_DISPENSE) || (state_nx == S_RETURN);
      sold_out    <= (stock_nx == '0);
    end
  end

endmodule
